muldiv_scheduler: RTL and testbench

MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

---
 rtl/muldiv_scheduler.sv | 132 +++++++++++++
 tb/tb_muldiv_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_scheduler.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers and the
// pipeline stall/hazard logic for MFHI/MFLO and back-to-back mul/div issue.
module muldiv_scheduler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        hilo_read_i,
  input  logic        muldiv_id_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_by_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_dbz;
  logic [W-1:0]    r_opnd;
  logic [W-1:0]    r_acc_hi;
  logic [W-1:0]    r_acc_lo;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_accept;
  logic            w_div0;
  logic            w_signed;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W:0]      w_add;
  logic [W:0]      w_shl;
  logic [W:0]      w_diff;
  logic            w_ge;
  logic [W-1:0]    w_hi_it;
  logic [W-1:0]    w_lo_it;
  logic [2*W-1:0]  w_prod_neg;
  logic [W-1:0]    w_res_hi;
  logic [W-1:0]    w_res_lo;

  assign w_accept = start_i & ~flush_i & (r_state != S_RUN);
  assign w_div0   = op_i[1] & (src_b_i == '0);
  assign w_signed = ~op_i[0];
  assign w_mag_a  = (w_signed & src_a_i[W-1]) ? W'(-src_a_i) : src_a_i;
  assign w_mag_b  = (w_signed & src_b_i[W-1]) ? W'(-src_b_i) : src_b_i;

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  assign w_add   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : (W+1)'(0));
  assign w_shl   = {r_acc_hi, r_acc_lo[W-1]};
  assign w_diff  = w_shl - {1'b0, r_opnd};
  assign w_ge    = ~w_diff[W];
  assign w_hi_it = r_is_div ? (w_ge ? w_diff[W-1:0] : w_shl[W-1:0]) : w_add[W:1];
  assign w_lo_it = r_is_div ? {r_acc_lo[W-2:0], w_ge} : {w_add[0], r_acc_lo[W-1:1]};

  assign w_prod_neg = (2*W)'(-{w_hi_it, w_lo_it});
  assign w_res_hi   = r_is_div ? (r_neg_rem ? W'(-w_hi_it) : w_hi_it)
                               : (r_neg_res ? w_prod_neg[2*W-1:W] : w_hi_it);
  assign w_res_lo   = r_is_div ? (r_neg_res ? W'(-w_lo_it) : w_lo_it)
                               : (r_neg_res ? w_prod_neg[W-1:0] : w_lo_it);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_div0 ? S_DONE : S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (r_cnt == CW'(31)) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_opnd    <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_is_div  <= op_i[1];
      r_neg_res <= w_signed & (src_a_i[W-1] ^ src_b_i[W-1]);
      r_neg_rem <= w_signed & src_a_i[W-1];
      r_dbz     <= w_div0;
      r_opnd    <= op_i[1] ? w_mag_b : w_mag_a;
      r_acc_hi  <= '0;
      r_acc_lo  <= op_i[1] ? w_mag_a : w_mag_b;
    end else if (r_state == S_RUN) begin
      r_cnt    <= r_cnt + CW'(1);
      r_acc_hi <= w_hi_it;
      r_acc_lo <= w_lo_it;
      if (r_cnt == CW'(31)) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign busy_o        = (r_state == S_RUN);
  assign done_o        = (r_state == S_DONE);
  assign div_by_zero_o = (r_state == S_DONE) & r_dbz;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign stall_o       = ((r_state == S_RUN) | w_accept) & (hilo_read_i | muldiv_id_i);

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Scoreboard bench for muldiv_scheduler: arithmetic reference model, per-cycle
// busy/stall/done timing checks, directed corner cases and random operations.
module tb_muldiv_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        flush_i = 1'b0;
  logic        hilo_read_i = 1'b0;
  logic        muldiv_id_i = 1'b0;
  logic        stall_o, busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  muldiv_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .hilo_read_i(hilo_read_i), .muldiv_id_i(muldiv_id_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          run_lo = 1;
  int          run_hi = 0;
  int          next_free = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          force_hilo = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic straight from the ISA rules
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo, output logic dbz);
    longint      p;
    logic [63:0] u;
    int          sa, sbv;
    dbz = 1'b0;
    case (op)
      2'b00: begin
        p  = longint'(int'(a)) * longint'(int'(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        u  = {32'h0, a} * {32'h0, b};
        hi = u[63:32];
        lo = u[31:0];
      end
      2'b10: begin
        if (b == 32'h0) dbz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          sa  = a;
          sbv = b;
          lo  = sa / sbv;
          hi  = sa % sbv;
        end
      end
      default: begin
        if (b == 32'h0) dbz = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Monitor: timing of busy/stall/done every cycle, results popped on done_o
  always @(negedge clk_i) begin
    bit   eb, ea;
    exp_t e;
    eb = (cyc >= run_lo) && (cyc <= run_hi);
    ea = start_i & ~flush_i & ~eb;
    if (!rst_i) begin
      chk("busy", 64'(busy_o), 64'(eb));
      chk("stall", 64'(stall_o), 64'((eb | ea) & (hilo_read_i | muldiv_id_i)));
      if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        checks++;
        failures++;
        $display("FAIL done_timeout actual=none required=done_at_%0d cyc=%0d", sb[0].done_cyc, cyc);
        void'(sb.pop_front());
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("hi", 64'(hi_o), 64'(e.hi));
          chk("lo", 64'(lo_o), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero_o), 64'(e.dbz));
        end
      end else begin
        chk("dbz_outside_done", 64'(div_by_zero_o), 64'(0));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      hilo_read_i = force_hilo | ($urandom % 4 == 0);
      muldiv_id_i = ~force_hilo & ($urandom % 5 == 0);
    end
  end

  task automatic wait_ready(input bit bb);
    if (!bb) repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
    while (cyc < next_free) begin @(posedge clk_i); #1; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit bb);
    exp_t e;
    logic dz;
    wait_ready(bb);
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    model(op, a, b, m_hi, m_lo, dz);
    e.hi = m_hi;
    e.lo = m_lo;
    e.dbz = dz;
    e.done_cyc = cyc + (dz ? 1 : 33);
    sb.push_back(e);
    if (!dz) begin
      run_lo = cyc + 1;
      run_hi = cyc + 32;
    end
    next_free = e.done_cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i    = 2'($urandom);
    src_a_i = $urandom;
    src_b_i = $urandom;
  endtask

  task automatic flush_try();
    wait_ready(1'b0);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'($urandom);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    int          guard;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    issue(2'b11, 32'd100, 32'h0, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'd7, 32'h0, 1'b1);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // MFHI held across a full operation, then back-to-back issue from DONE
    wait_ready(1'b0);
    force_hilo  = 1'b1;
    hilo_read_i = 1'b1;
    muldiv_id_i = 1'b0;
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    issue(2'b11, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);
    force_hilo = 1'b0;

    flush_try();
    flush_try();

    // Asynchronous reset in the middle of a run discards the operation
    issue(2'b00, 32'h0000_1234, 32'hFFFF_0001, 1'b0);
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    sb.delete();
    run_lo = 1;
    run_hi = 0;
    next_free = 0;
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midrun_rst_hi", 64'(hi_o), 64'(0));
    chk("midrun_rst_lo", 64'(lo_o), 64'(0));
    chk("midrun_rst_busy", 64'(busy_o), 64'(0));
    chk("midrun_rst_done", 64'(done_o), 64'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    issue(2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom % 8 == 0) ? 32'h0 : $urandom;
      if ($urandom % 4 == 0) b = b & 32'h0000_00FF;
      if ($urandom % 10 == 0) flush_try();
      issue(2'($urandom), a, b, ($urandom % 2 == 0));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(posedge clk_i);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
    end
    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
